// File: rtl/acc_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// acc_mem_arbiter_if
// Bundles the accelerator request/response lines and the Data Memory
// accelerator-port lines that pass through acc_mem_arbiter.
//   slave  modport : seen by the arbiter (accelerator requests in, memory
//                    strobes out, responses out)
//   master modport : seen by the environment (accelerator control units and
//                    the memory model)
// Signal groups:
//   acc_read_*  / acc_write_*  per-accelerator request and response lines,
//                              flattened, slice i belongs to accelerator i
//   cpu_mem_busy               CPU owns memory this cycle
//   mem_read_* / mem_write_*   single shared memory port
// ----------------------------------------------------------------------------
interface acc_mem_arbiter_if #(
    parameter int NUM_ACC         = 4,
    parameter int ADDR_SIZE       = 16,
    parameter int READ_DATA_SIZE  = 512,
    parameter int WRITE_DATA_SIZE = 32
);
    logic [NUM_ACC-1:0]                 acc_read_en;
    logic [NUM_ACC*ADDR_SIZE-1:0]       acc_read_addr;
    logic [READ_DATA_SIZE-1:0]          acc_read_data;
    logic [NUM_ACC-1:0]                 acc_read_data_valid;
    logic [NUM_ACC-1:0]                 acc_write_en;
    logic [NUM_ACC*ADDR_SIZE-1:0]       acc_write_addr;
    logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data;
    logic [NUM_ACC-1:0]                 acc_write_done;
    logic                               cpu_mem_busy;
    logic                               mem_read_en;
    logic [ADDR_SIZE-1:0]               mem_read_addr;
    logic [READ_DATA_SIZE-1:0]          mem_read_data;
    logic                               mem_write_en;
    logic [ADDR_SIZE-1:0]               mem_write_addr;
    logic [WRITE_DATA_SIZE-1:0]         mem_write_data;

    modport slave (
        input  acc_read_en, acc_read_addr, acc_write_en, acc_write_addr,
               acc_write_data, cpu_mem_busy, mem_read_data,
        output acc_read_data, acc_read_data_valid, acc_write_done,
               mem_read_en, mem_read_addr, mem_write_en, mem_write_addr,
               mem_write_data
    );

    modport master (
        output acc_read_en, acc_read_addr, acc_write_en, acc_write_addr,
               acc_write_data, cpu_mem_busy, mem_read_data,
        input  acc_read_data, acc_read_data_valid, acc_write_done,
               mem_read_en, mem_read_addr, mem_write_en, mem_write_addr,
               mem_write_data
    );
endinterface

// File: rtl/acc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// acc_mem_arbiter
// Shares the single Data Memory accelerator port among NUM_ACC accelerator
// control units. One read (one line) or one write (one word) is in flight at a
// time; completion is signalled with a one-cycle, one-hot
// acc_read_data_valid / acc_write_done pulse to the granted accelerator.
// The CPU has absolute priority: while cpu_mem_busy is high no strobe is issued.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    acc_mem_arbiter_if.slave (accelerator and memory-port signals)
//
// Configuration macro:
//   ACC_MEM_ARB_FIXED_PRIO_EN  defined   -> lowest requesting index always wins
//                              undefined -> round-robin starting at rr_ptr
// ----------------------------------------------------------------------------
module acc_mem_arbiter #(
    parameter int NUM_ACC          = 4,
    parameter int ADDR_SIZE        = 16,
    parameter int READ_DATA_SIZE   = 512,
    parameter int WRITE_DATA_SIZE  = 32,
    parameter int MEM_READ_LATENCY = 1
) (
    input logic               clk,
    input logic               rst_n,
    acc_mem_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int CNT_W = $clog2(MEM_READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_RD_RESP  = 3'd3,
        S_WR_ISSUE = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            lat_cnt_q, lat_cnt_d;
    logic [READ_DATA_SIZE-1:0]   rd_data_q, rd_data_d;

    logic [NUM_ACC-1:0]          req_s;
    logic                        win_found_s;
    logic [IDX_W-1:0]            win_idx_s;
    int                          start_s;

    logic                        mem_read_en_s;
    logic [ADDR_SIZE-1:0]        mem_read_addr_s;
    logic                        mem_write_en_s;
    logic [ADDR_SIZE-1:0]        mem_write_addr_s;
    logic [WRITE_DATA_SIZE-1:0]  mem_write_data_s;
    logic [NUM_ACC-1:0]          valid_s;
    logic [NUM_ACC-1:0]          done_s;

    // Request scan: first set request at or after the start index (wrapping) wins.
    always_comb begin
        req_s       = bus.acc_read_en | bus.acc_write_en;
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef ACC_MEM_ARB_FIXED_PRIO_EN
        start_s     = 0;
`else
        start_s     = int'(rr_ptr_q);
`endif
        for (int k = 0; k < NUM_ACC; k++) begin
            if (!win_found_s && req_s[(start_s + k) % NUM_ACC]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'((start_s + k) % NUM_ACC);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and output decode for the transaction FSM.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        idx_d            = idx_q;
        lat_cnt_d        = lat_cnt_q;
        rd_data_d        = rd_data_q;
        mem_read_en_s    = 1'b0;
        mem_read_addr_s  = '0;
        mem_write_en_s   = 1'b0;
        mem_write_addr_s = '0;
        mem_write_data_s = '0;
        valid_s          = '0;
        done_s           = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found_s) begin
                    idx_d     = win_idx_s;
                    lat_cnt_d = '0;
`ifdef ACC_MEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d  = '0;
`else
                    rr_ptr_d  = IDX_W'((int'(win_idx_s) + 1) % NUM_ACC);
`endif
                    // A winner holding both requests is served read-first.
                    if (bus.acc_read_en[win_idx_s]) begin
                        state_d = S_RD_ISSUE;
                    end else begin
                        state_d = S_WR_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RD_ISSUE: begin
                mem_read_addr_s = bus.acc_read_addr[int'(idx_q)*ADDR_SIZE +: ADDR_SIZE];
                if (!bus.cpu_mem_busy) begin
                    mem_read_en_s = 1'b1;
                    lat_cnt_d     = CNT_W'(1);
                    state_d       = S_RD_WAIT;
                end else begin
                    state_d       = S_RD_ISSUE;
                end
            end

            // Memory owns the read now; cpu_mem_busy cannot abort it.
            S_RD_WAIT: begin
                if (lat_cnt_q == CNT_W'(MEM_READ_LATENCY)) begin
                    rd_data_d = bus.mem_read_data;
                    state_d   = S_RD_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end

            S_RD_RESP: begin
                valid_s[idx_q] = 1'b1;
                lat_cnt_d      = '0;
                state_d        = S_IDLE;
            end

            // Done is combinational with the strobe: the word is committed this cycle.
            S_WR_ISSUE: begin
                mem_write_addr_s = bus.acc_write_addr[int'(idx_q)*ADDR_SIZE +: ADDR_SIZE];
                mem_write_data_s = bus.acc_write_data[int'(idx_q)*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
                if (!bus.cpu_mem_busy) begin
                    mem_write_en_s = 1'b1;
                    done_s[idx_q]  = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    state_d        = S_WR_ISSUE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            lat_cnt_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            lat_cnt_q <= lat_cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.acc_read_data       = rd_data_q;
    assign bus.acc_read_data_valid = valid_s;
    assign bus.acc_write_done      = done_s;
    assign bus.mem_read_en         = mem_read_en_s;
    assign bus.mem_read_addr       = mem_read_addr_s;
    assign bus.mem_write_en        = mem_write_en_s;
    assign bus.mem_write_addr      = mem_write_addr_s;
    assign bus.mem_write_data      = mem_write_data_s;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_acc_mem_arbiter
// Directed scoreboard bench for acc_mem_arbiter. Stimulus pushes the expected
// memory strobes and response pulses (with their cycle numbers) into a queue;
// a negedge monitor pops and compares whenever the DUT shows an event.
// A small memory model returns a line derived from the address after
// MEM_READ_LATENCY cycles.
// ----------------------------------------------------------------------------
module tb_acc_mem_arbiter;

    localparam int NUM_ACC = 4;
    localparam int AW      = 16;
    localparam int RW      = 512;
    localparam int WW      = 32;
    localparam int LAT     = 1;

    typedef enum int {EV_RD_ISS = 0, EV_RD_VAL = 1, EV_WR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        int            idx;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        logic [RW-1:0] rdata;
        int            cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic hold_reqs = 1'b0;
    logic [NUM_ACC-1:0] pulse_rd = '0;
    logic [NUM_ACC-1:0] pulse_wr = '0;
    ev_t  exp_q[$];

    acc_mem_arbiter_if #(.NUM_ACC(NUM_ACC), .ADDR_SIZE(AW),
                         .READ_DATA_SIZE(RW), .WRITE_DATA_SIZE(WW)) bus ();

    acc_mem_arbiter #(.NUM_ACC(NUM_ACC), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW),
                      .WRITE_DATA_SIZE(WW), .MEM_READ_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory line contents as a function of the address.
    function automatic logic [RW-1:0] line_of(input logic [AW-1:0] a);
        logic [RW-1:0] l;
        for (int j = 0; j < RW/32; j++) l[j*32 +: 32] = {a + 16'(j), ~a};
        return l;
    endfunction

    // Memory model: read data appears LAT cycles after the strobe.
    logic [LAT-1:0] pv = '0;
    logic [AW-1:0]  pa [LAT];
    always @(posedge clk) begin
        pv[0] <= bus.mem_read_en;
        pa[0] <= bus.mem_read_addr;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign bus.mem_read_data = pv[LAT-1] ? line_of(pa[LAT-1]) : '0;

    task automatic cmp(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_event(input ev_kind_t kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            cmp("ev_kind", RW'(kind), RW'(e.kind));
            cmp("ev_cycle", RW'(cyc), RW'(e.cyc));
            case (kind)
                EV_RD_ISS: cmp("mem_read_addr", RW'(bus.mem_read_addr), RW'(e.addr));
                EV_RD_VAL: begin
                    cmp("read_valid", RW'(bus.acc_read_data_valid), RW'(4'b0001 << e.idx));
                    cmp("read_data", bus.acc_read_data, e.rdata);
                end
                EV_WR: begin
                    cmp("write_en", RW'(bus.mem_write_en), RW'(1'b1));
                    cmp("write_done", RW'(bus.acc_write_done), RW'(4'b0001 << e.idx));
                    cmp("write_addr", RW'(bus.mem_write_addr), RW'(e.addr));
                    cmp("write_data", RW'(bus.mem_write_data), RW'(e.wdata));
                end
                default: cmp("ev_kind_legal", RW'(kind), RW'(0));
            endcase
        end
    endtask

    // Monitor: sample away from the active edge and score every DUT event.
    always @(negedge clk) begin
        pulse_rd = bus.acc_read_data_valid;
        pulse_wr = bus.acc_write_done;
        if (rst_n) begin
            if (bus.mem_read_en) check_event(EV_RD_ISS);
            if (bus.acc_read_data_valid != '0) check_event(EV_RD_VAL);
            if (bus.mem_write_en || bus.acc_write_done != '0) check_event(EV_WR);
            if (bus.mem_read_en && bus.mem_write_en) begin
                n_tests++; n_fail++;
                $display("FAIL both_strobes: got rd=1 wr=1 expected at most one, cycle %0d", cyc);
            end
            if ($countones(bus.acc_read_data_valid | bus.acc_write_done) > 1) begin
                n_tests++; n_fail++;
                $display("FAIL pulse_onehot: got %0b expected at most one bit, cycle %0d",
                         bus.acc_read_data_valid | bus.acc_write_done, cyc);
            end
        end
    end

    // Advance one cycle; inputs change 1 time unit after the active edge.
    // A control unit drops its request after seeing its pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_reqs) begin
            bus.acc_read_en  = bus.acc_read_en & ~pulse_rd;
            bus.acc_write_en = bus.acc_write_en & ~pulse_wr;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic push_ev(input ev_kind_t k, input int idx, input logic [AW-1:0] a,
                           input logic [WW-1:0] wd, input int c);
        ev_t e;
        e.kind = k; e.idx = idx; e.addr = a; e.wdata = wd; e.cyc = c;
        e.rdata = line_of(a);
        exp_q.push_back(e);
    endtask

    // Read with no busy: strobe at iss, capture iss+1, valid pulse iss+2.
    task automatic push_rd(input int idx, input logic [AW-1:0] a, input int iss);
        push_ev(EV_RD_ISS, idx, a, '0, iss);
        push_ev(EV_RD_VAL, idx, a, '0, iss + 2);
    endtask

    int k;

    initial begin
        bus.acc_read_en    = '0;
        bus.acc_write_en   = '0;
        bus.acc_read_addr  = '0;
        bus.acc_write_addr = '0;
        bus.acc_write_data = '0;
        bus.cpu_mem_busy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state
        @(negedge clk);
        cmp("rst_read_data", bus.acc_read_data, '0);
        cmp("rst_valid", RW'(bus.acc_read_data_valid), '0);
        cmp("rst_done", RW'(bus.acc_write_done), '0);
        cmp("rst_mem_read_en", RW'(bus.mem_read_en), '0);
        cmp("rst_mem_write_en", RW'(bus.mem_write_en), '0);
        cmp("rst_mem_read_addr", RW'(bus.mem_read_addr), '0);
        cmp("rst_mem_write_addr", RW'(bus.mem_write_addr), '0);
        cmp("rst_mem_write_data", RW'(bus.mem_write_data), '0);
        tick();

        // 1: acc0 single read
        k = cyc;
        bus.acc_read_addr[0*AW +: AW] = 16'h1000;
        bus.acc_read_en[0] = 1'b1;
        push_rd(0, 16'h1000, k + 1);
        repeat (10) tick();

        // 2: acc0 and acc2 from reset, then acc0+acc3 to show rr_ptr moved to 3
        do_reset();
        k = cyc;
        bus.acc_read_addr[0*AW +: AW] = 16'h1111;
        bus.acc_read_addr[2*AW +: AW] = 16'h2222;
        bus.acc_read_en = 4'b0101;
        push_rd(0, 16'h1111, k + 1);
        push_rd(2, 16'h2222, k + 5);
        repeat (12) tick();
        k = cyc;
        bus.acc_read_addr[0*AW +: AW] = 16'h0AAA;
        bus.acc_read_addr[3*AW +: AW] = 16'h3333;
        bus.acc_read_en = 4'b1001;
        push_rd(3, 16'h3333, k + 1);
        push_rd(0, 16'h0AAA, k + 5);
        repeat (12) tick();

        // 3: acc1 write under 3 busy cycles
        k = cyc;
        bus.acc_write_addr[1*AW +: AW] = 16'h5000;
        bus.acc_write_data[1*WW +: WW] = 32'h0000_0005;
        bus.acc_write_en[1] = 1'b1;
        bus.cpu_mem_busy = 1'b1;
        push_ev(EV_WR, 1, 16'h5000, 32'h0000_0005, k + 3);
        repeat (3) tick();
        bus.cpu_mem_busy = 1'b0;
        repeat (8) tick();

        // 4: acc3 read+write together: read first, then the held write
        k = cyc;
        bus.acc_read_addr[3*AW +: AW]  = 16'h3000;
        bus.acc_write_addr[3*AW +: AW] = 16'h3100;
        bus.acc_write_data[3*WW +: WW] = 32'hCAFE_0003;
        bus.acc_read_en[3]  = 1'b1;
        bus.acc_write_en[3] = 1'b1;
        push_rd(3, 16'h3000, k + 1);
        push_ev(EV_WR, 3, 16'h3100, 32'hCAFE_0003, k + 5);
        repeat (12) tick();

        // 5: reset while in RD_WAIT aborts the read
        k = cyc;
        bus.acc_read_addr[2*AW +: AW] = 16'h2000;
        bus.acc_read_en[2] = 1'b1;
        push_ev(EV_RD_ISS, 2, 16'h2000, '0, k + 1);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.acc_read_en[2] = 1'b0;
        @(negedge clk);
        cmp("abort_read_data", bus.acc_read_data, '0);
        cmp("abort_valid", RW'(bus.acc_read_data_valid), '0);
        cmp("abort_mem_read_en", RW'(bus.mem_read_en), '0);
        repeat (10) tick();

        // 6: acc0 and acc1 hold write requests continuously from reset
        do_reset();
        k = cyc;
        bus.acc_write_addr[0*AW +: AW] = 16'h0600;
        bus.acc_write_data[0*WW +: WW] = 32'h0000_0060;
        bus.acc_write_addr[1*AW +: AW] = 16'h0610;
        bus.acc_write_data[1*WW +: WW] = 32'h0000_0061;
        hold_reqs = 1'b1;
        bus.acc_write_en = 4'b0011;
`ifdef ACC_MEM_ARB_FIXED_PRIO_EN
        for (int g = 0; g < 4; g++)
            push_ev(EV_WR, 0, 16'h0600, 32'h0000_0060, k + 1 + 2*g);
`else
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) push_ev(EV_WR, 0, 16'h0600, 32'h0000_0060, k + 1 + 2*g);
            else            push_ev(EV_WR, 1, 16'h0610, 32'h0000_0061, k + 1 + 2*g);
        end
`endif
        repeat (8) tick();
        bus.acc_write_en = '0;
        hold_reqs = 1'b0;
        repeat (8) tick();

        // Every expected event must have been observed
        cmp("pending_events", RW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
